// File: rtl/sdf_stage_ctrl_pkg.sv
// Shared definitions for the SDF FFT stage controllers: default geometry and
// the sequencer state encoding.
package fft_pkg;

    localparam int unsigned DELAY_DEF = 512;
    localparam int unsigned CNT_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } stage_state_e;

endpackage

// File: rtl/sdf_stage_ctrl_if.sv
// Handshake and control bundle between an SDF stage controller and its
// upstream source / downstream datapath.
interface sdf_stage_ctrl_if
    import fft_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             in_valid;
    logic             shift_en;
    logic             bf_sel;
    logic             out_valid;
    logic             out_first;
    logic             tw_en;
    logic [CNT_W-2:0] tw_addr;
    logic             busy;
    logic             err;

    modport master (
        output in_valid,
        input  shift_en, bf_sel, out_valid, out_first, tw_en, tw_addr, busy, err
    );

    modport slave (
        input  in_valid,
        output shift_en, bf_sel, out_valid, out_first, tw_en, tw_addr, busy, err
    );

endinterface

// File: rtl/sdf_stage_ctrl_mod_counter.sv
// Wrapping binary counter with enable, synchronous clear and a terminal-count
// flag raised while the count equals TC.
module mod_counter #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned TC    = 511
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == WIDTH'(TC));

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF stage: delay-line shift, butterfly select,
// output valid/frame markers, twiddle addressing and post-stream flush.
module sdf_stage_ctrl
    import fft_pkg::*;
#(
    parameter int unsigned DELAY = DELAY_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    sdf_stage_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] FIRST_BF = CNT_W'(DELAY);

    stage_state_e     state_q, state_d;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-2:0] fcnt;
    logic             cnt_tc, fcnt_tc;
    logic             cnt_en, cnt_clr;
    logic             fcnt_en, fcnt_clr;

    logic             shift_en, bf_sel;
    logic             out_valid_q, out_valid_d;
    logic             out_first_q, out_first_d;
    logic             tw_en_q, tw_en_d;
    logic [CNT_W-2:0] tw_addr_q, tw_addr_d;
    logic             busy_q;
    logic             err_q, err_d;

    mod_counter #(
        .WIDTH (CNT_W),
        .TC    (DELAY - 1)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (cnt_en),
        .clr_i   (cnt_clr),
        .count_o (cnt),
        .tc_o    (cnt_tc)
    );

    mod_counter #(
        .WIDTH (CNT_W - 1),
        .TC    (DELAY - 1)
    ) u_fcnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (fcnt_en),
        .clr_i   (fcnt_clr),
        .count_o (fcnt),
        .tc_o    (fcnt_tc)
    );

    always_comb begin
        state_d     = state_q;
        shift_en    = 1'b0;
        bf_sel      = 1'b0;
        cnt_en      = 1'b0;
        fcnt_en     = 1'b0;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        tw_en_d     = 1'b0;
        tw_addr_d   = '0;
        err_d       = err_q;
        cnt_clr     = (state_q == FLUSH);
        fcnt_clr    = (state_q != FLUSH);

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shift_en = 1'b1;
                    cnt_en   = 1'b1;
                    state_d  = FILL;
                end
            end

            FILL: begin
                shift_en = bus.in_valid;
                cnt_en   = bus.in_valid;
                if (bus.in_valid && cnt_tc) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                shift_en = bus.in_valid;
                cnt_en   = bus.in_valid;
                bf_sel   = cnt[CNT_W-1];
                if (bus.in_valid) begin
                    // second half emits sums; first half drains the previous frame's differences
                    out_valid_d = 1'b1;
                    out_first_d = (cnt == FIRST_BF);
                    tw_en_d     = !cnt[CNT_W-1];
                    tw_addr_d   = cnt[CNT_W-1] ? '0 : cnt[CNT_W-2:0];
                end else if (cnt == '0) begin
                    state_d = FLUSH;
                end
            end

            FLUSH: begin
                shift_en    = 1'b1;
                fcnt_en     = 1'b1;
                out_valid_d = 1'b1;
                tw_en_d     = 1'b1;
                tw_addr_d   = fcnt;
                err_d       = err_q | bus.in_valid;
                if (fcnt_tc) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            tw_en_q     <= 1'b0;
            tw_addr_q   <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            tw_en_q     <= tw_en_d;
            tw_addr_q   <= tw_addr_d;
            busy_q      <= (state_d != IDLE);
            err_q       <= err_d;
        end
    end

    // Mealy strobes are masked by rst_n so a sample arriving during reset never shifts
    assign bus.shift_en  = shift_en & rst_n;
    assign bus.bf_sel    = bf_sel & rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.out_first = out_first_q;
    assign bus.tw_en     = tw_en_q;
    assign bus.tw_addr   = tw_addr_q;
    assign bus.busy      = busy_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Randomised and directed bench for sdf_stage_ctrl at DELAY=512 and DELAY=4,
// compared every cycle against a sample-count reference model.
module tb_sdf_stage_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_cfg
        localparam int unsigned D  = (g == 0) ? 512 : 4;
        localparam int unsigned CW = (g == 0) ? 10 : 3;

        sdf_stage_ctrl_if #(.CNT_W(CW)) bus ();
        assign bus.in_valid = in_valid;

        sdf_stage_ctrl #(.DELAY(D), .CNT_W(CW)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        // Reference: n = samples accepted in the current stream, fl = flush cycles left.
        int n = 0, fl = 0;
        bit strm = 0;
        bit m_ov = 0, m_of = 0, m_te = 0, m_bsy = 0, m_err = 0;
        int m_ta = 0;
        int idx;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                n = 0; fl = 0; strm = 0;
                m_ov = 0; m_of = 0; m_te = 0; m_ta = 0; m_bsy = 0; m_err = 0;
            end else begin
                m_ov = 0; m_of = 0; m_te = 0; m_ta = 0;
                if (fl > 0) begin
                    m_ov = 1; m_te = 1; m_ta = int'(D) - fl;
                    if (in_valid) m_err = 1;
                    fl--;
                end else if (strm) begin
                    if (in_valid) begin
                        idx = n % (2 * D);
                        if (n >= int'(D)) begin
                            m_ov = 1;
                            m_of = (idx == int'(D));
                            m_te = (idx < int'(D));
                            m_ta = (idx < int'(D)) ? idx : 0;
                        end
                        n++;
                    end else if (n >= int'(2 * D) && (n % (2 * D)) == 0) begin
                        strm = 0;
                        fl = D;
                    end
                end else if (in_valid) begin
                    strm = 1;
                    n = 1;
                end
                m_bsy = strm || (fl > 0);
            end
        end

        // Observation counters for the directed literal checks.
        int ov_cnt = 0, of_cnt = 0, te_cnt = 0, sh_cnt = 0;
        int ov_rise = -1, iv_rise = -1, iv_fall = -1, bsy_fall = -1, of_first = -1, of_last = -1;
        bit p_ov = 0, p_iv = 0, p_bsy = 0;
        bit e_sh, e_bf;

        always @(negedge clk) begin
            e_sh = rst_n && ((fl > 0) || in_valid);
            e_bf = rst_n && (fl == 0) && strm && (n >= int'(D)) && ((n % (2 * D)) >= int'(D));
            check($sformatf("cfg%0d.shift_en", g), 32'(bus.shift_en), 32'(e_sh));
            check($sformatf("cfg%0d.bf_sel", g), 32'(bus.bf_sel), 32'(e_bf));
            check($sformatf("cfg%0d.out_valid", g), 32'(bus.out_valid), 32'(m_ov));
            check($sformatf("cfg%0d.out_first", g), 32'(bus.out_first), 32'(m_of));
            check($sformatf("cfg%0d.tw_en", g), 32'(bus.tw_en), 32'(m_te));
            check($sformatf("cfg%0d.tw_addr", g), 32'(bus.tw_addr), 32'(m_ta));
            check($sformatf("cfg%0d.busy", g), 32'(bus.busy), 32'(m_bsy));
            check($sformatf("cfg%0d.err", g), 32'(bus.err), 32'(m_err));

            if (bus.out_valid) ov_cnt++;
            if (bus.out_valid && bus.tw_en) te_cnt++;
            if (bus.shift_en) sh_cnt++;
            if (bus.out_first) begin
                of_cnt++;
                if (of_first < 0) of_first = cyc;
                of_last = cyc;
            end
            if (bus.out_valid && !p_ov && ov_rise < 0) ov_rise = cyc;
            if (in_valid && !p_iv && iv_rise < 0) iv_rise = cyc;
            if (!in_valid && p_iv) iv_fall = cyc;
            if (!bus.busy && p_bsy) bsy_fall = cyc;
            p_ov = bus.out_valid; p_iv = in_valid; p_bsy = bus.busy;
        end
    end

    task automatic arm();
        gen_cfg[0].ov_cnt = 0; gen_cfg[0].of_cnt = 0; gen_cfg[0].te_cnt = 0; gen_cfg[0].sh_cnt = 0;
        gen_cfg[0].ov_rise = -1; gen_cfg[0].iv_rise = -1; gen_cfg[0].of_first = -1;
        gen_cfg[1].ov_cnt = 0; gen_cfg[1].of_cnt = 0; gen_cfg[1].te_cnt = 0; gen_cfg[1].sh_cnt = 0;
        gen_cfg[1].ov_rise = -1; gen_cfg[1].iv_rise = -1; gen_cfg[1].of_first = -1;
    endtask

    task automatic cycle(input bit v);
        @(posedge clk);
        #1 in_valid = v;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Samples with optional random idle gaps; never idles on a 1024-sample boundary.
    task automatic send(input int nsamp, input int gap_pct);
        for (int i = 0; i < nsamp; i++) begin
            if (gap_pct > 0 && (i % 1024) != 0 && $urandom_range(99) < gap_pct)
                repeat ($urandom_range(3, 1)) cycle(1'b0);
            cycle(1'b1);
        end
        cycle(1'b0);
    endtask

    task automatic wait_idle(input int which);
        int k;
        k = 0;
        @(negedge clk);
        while (k < 5000 && ((which == 0) ? gen_cfg[0].bus.busy : gen_cfg[1].bus.busy)) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("cfg%0d.drain_timeout", which),
              32'((which == 0) ? gen_cfg[0].bus.busy : gen_cfg[1].bus.busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        do_reset();
        check("reset.out_valid", 32'(gen_cfg[0].bus.out_valid), 32'd0);
        check("reset.busy", 32'(gen_cfg[0].bus.busy), 32'd0);

        // One frame then drain.
        arm();
        send(1024, 0);
        wait_idle(0);
        check("f1.ov_count", 32'(gen_cfg[0].ov_cnt), 32'd1024);
        check("f1.tw_count", 32'(gen_cfg[0].te_cnt), 32'd512);
        check("f1.first_count", 32'(gen_cfg[0].of_cnt), 32'd1);
        check("f1.shift_count", 32'(gen_cfg[0].sh_cnt), 32'd1536);
        check("f1.latency", 32'(gen_cfg[0].ov_rise - gen_cfg[0].iv_rise), 32'd513);

        // Two contiguous frames.
        arm();
        send(2048, 0);
        wait_idle(0);
        check("f2.ov_count", 32'(gen_cfg[0].ov_cnt), 32'd2048);
        check("f2.tw_count", 32'(gen_cfg[0].te_cnt), 32'd1024);
        check("f2.first_count", 32'(gen_cfg[0].of_cnt), 32'd2);
        check("f2.first_spacing", 32'(gen_cfg[0].of_last - gen_cfg[0].of_first), 32'd1024);

        // Random mid-frame stalls.
        arm();
        send(2048, 30);
        wait_idle(0);
        check("gap.ov_count", 32'(gen_cfg[0].ov_cnt), 32'd2048);
        check("gap.first_count", 32'(gen_cfg[0].of_cnt), 32'd2);

        // in_valid pulses while flushing.
        arm();
        send(1024, 0);
        repeat (10) cycle(1'b0);
        cycle(1'b1); cycle(1'b0);
        repeat (5) cycle(1'b0);
        cycle(1'b1); cycle(1'b0);
        wait_idle(0);
        check("ferr.err", 32'(gen_cfg[0].bus.err), 32'd1);
        check("ferr.ov_count", 32'(gen_cfg[0].ov_cnt), 32'd1024);
        check("ferr.shift_count", 32'(gen_cfg[0].sh_cnt), 32'd1536);
        repeat (20) @(negedge clk);
        check("ferr.err_sticky", 32'(gen_cfg[0].bus.err), 32'd1);

        // Asynchronous reset at sample 700 with in_valid still high.
        do_reset();
        check("rst.err_cleared", 32'(gen_cfg[0].bus.err), 32'd0);
        for (int i = 0; i < 700; i++) cycle(1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst.shift_en", 32'(gen_cfg[0].bus.shift_en), 32'd0);
        check("arst.bf_sel", 32'(gen_cfg[0].bus.bf_sel), 32'd0);
        check("arst.out_valid", 32'(gen_cfg[0].bus.out_valid), 32'd0);
        check("arst.tw_en", 32'(gen_cfg[0].bus.tw_en), 32'd0);
        check("arst.tw_addr", 32'(gen_cfg[0].bus.tw_addr), 32'd0);
        check("arst.busy", 32'(gen_cfg[0].bus.busy), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        arm();
        send(1024, 0);
        wait_idle(0);
        check("restart.latency", 32'(gen_cfg[0].ov_rise - gen_cfg[0].iv_rise), 32'd513);
        check("restart.ov_count", 32'(gen_cfg[0].ov_cnt), 32'd1024);

        // Small instance: one 8-sample frame.
        do_reset();
        arm();
        send(8, 0);
        wait_idle(1);
        check("d4.latency", 32'(gen_cfg[1].ov_rise - gen_cfg[1].iv_rise), 32'd5);
        check("d4.busy_fall", 32'(gen_cfg[1].bsy_fall - gen_cfg[1].iv_fall), 32'd5);
        check("d4.ov_count", 32'(gen_cfg[1].ov_cnt), 32'd8);
        check("d4.tw_count", 32'(gen_cfg[1].te_cnt), 32'd4);
        check("d4.first_count", 32'(gen_cfg[1].of_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sdf_stage_ctrl.md
# sdf_stage_ctrl

Sequencer for one radix-2 single-path delay-feedback (SDF) stage of the 1024-point FFT pipeline. It counts accepted samples per 1024-sample frame and drives the stage's 512-deep delay line shift enable and the butterfly/bypass select. It also generates output-valid, frame markers and twiddle addresses for the stage multiplier, and drains the delay line after the last frame. Instantiated once per stage, beside the delay line and butterfly.

## Interface

- DELAY, default 512: delay-line depth (N/2); power of two, ≥2.
- CNT_W, default 10: frame counter width, log2(2·DELAY).

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample present this cycle
- shift_en  out  1  delay-line shift strobe (combinational)
- bf_sel  out  1  1 = butterfly (second half), 0 = bypass/fill (combinational)
- out_valid  out  1  stage output valid (registered)
- out_first  out  1  pulse with first output of each frame (registered)
- tw_en  out  1  current output is a difference term; multiply by twiddle (registered)
- tw_addr  out  CNT_W-1  twiddle index k, 0..DELAY-1 (registered)
- busy  out  1  state ≠ IDLE (registered)
- err  out  1  sticky: in_valid seen during FLUSH; cleared only by reset

## Operation

- States: IDLE, FILL, RUN, FLUSH. Counter cnt (CNT_W bits) counts accepted samples mod 2·DELAY; fcnt (CNT_W-1 bits) counts flush cycles.
- IDLE: shift_en=0, bf_sel=0. in_valid=1 → FILL, sample accepted, cnt←1.
- FILL: shift_en=in_valid, bf_sel=0, no outputs. Accepting sample index DELAY-1 → RUN.
- RUN: shift_en=in_valid; bf_sel=cnt[CNT_W-1] (1 for indices DELAY..2·DELAY-1). Each accepted sample produces one output.
  - Second half: sum output, tw_en=0, tw_addr=0.
  - First half of the following frame: difference output from delay line, tw_en=1, tw_addr=cnt[CNT_W-2:0].
- Mid-frame in_valid=0: stall. Nothing shifts and cnt holds; legal in FILL and RUN.
- Frame boundary (RUN, cnt==0) with in_valid=0 → FLUSH. A frame is therefore ended by one idle cycle after its last sample; back-to-back frames must be contiguous at the boundary.
- FLUSH: shift_en=1 every cycle, bf_sel=0, outputs = pending differences, tw_en=1, tw_addr=fcnt. After DELAY cycles (fcnt==DELAY-1) → IDLE. in_valid during FLUSH is ignored and sets err.
- cnt wraps 2·DELAY-1→0 without state change in RUN. Stall at cnt==DELAY-1 in FILL stays in FILL.

## Timing

- shift_en and bf_sel are Mealy outputs, same cycle as in_valid, so the delay line and butterfly capture the sample in that cycle.
- out_valid/out_first/tw_en/tw_addr lag the accepting cycle by exactly 1 clock, aligned with the registered butterfly output.
- out_valid = registered (shift_en && state∈{RUN,FLUSH}).
- out_first = registered (RUN, accepting index DELAY).
- Reset (any time, including mid-frame or mid-flush): state=IDLE, cnt=fcnt=0. All registered outputs 0, err=0. shift_en=bf_sel=0 until the first post-reset in_valid. The delay line is cleared by the same rst_n.
- First output latency: DELAY+1 cycles after first accepted sample (contiguous input). Last output: DELAY cycles after FLUSH entry +1.

## Structure

- Package fft_pkg: DELAY/CNT_W constants, state enum (IDLE, FILL, RUN, FLUSH), shared with the other stage controllers.
- One sub-module: mod_counter (wrapping counter with enable, terminal-count flag); instantiated twice, for cnt and fcnt. FSM and output registers live in sdf_stage_ctrl.

## Test plan

- Reset then 1024 contiguous in_valid then 1 idle → shift_en high 1024+512 cycles. out_valid first at cycle 513 after first sample with out_first=1. Exactly 1024 out_valid cycles; tw_en=1 on the last 512 with tw_addr 0..511.
- Two back-to-back frames (2048 contiguous) → second frame's first 512 outputs have tw_en=1, tw_addr 0..511. Exactly two out_first pulses, 1024 cycles apart.
- Random in_valid gaps mid-frame (30% idle) → cnt holds during gaps; output count per frame still 1024; bf_sel toggles only on accepted index 512 and 0.
- in_valid pulsed during FLUSH → err=1 and stays 1; FLUSH length still 512; no extra out_valid.
- rst_n asserted at sample 700 of RUN → all outputs 0 same cycle (async). Next in_valid restarts in FILL with cnt=1.
- DELAY=4, CNT_W=3 → 8-sample frame; first out_valid 5 cycles after first sample, flush 4 cycles, busy falls the cycle after flush ends.
